ram_bist_pbuf: RTL

RAM_BIST_PBUF -- requirements
Module: ram_bist_pbuf

---
 rtl/ram_bist_pbuf.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ram_bist_pbuf.sv
// Dual-port word RAM with a counted write port and a read port that streams
// bursts through a two-entry skid buffer under downstream ready/valid control.
module ram_bist_pbuf #(
    parameter int DW      = 64,
    parameter int AW      = 8,
    parameter int BSEL_ID = 0
) (
    input  logic          USER_CLK,
    input  logic          USER_RST_N,

    input  logic          RAM_WR_REQ,
    input  logic [15:0]   RAM_WR_ADDR,
    input  logic [15:0]   RAM_WR_SIZE,
    input  logic [15:0]   RAM_WR_BSEL,
    input  logic [DW-1:0] RAM_WR_DATA,
    input  logic          RAM_WR_DVLD,
    input  logic          RAM_WR_SOP,
    input  logic          RAM_WR_EOP,
    output logic          RAM_WR_ERR,

    input  logic          RAM_RD_REQ,
    input  logic [15:0]   RAM_RD_ADDR,
    input  logic [15:0]   RAM_RD_SIZE,
    input  logic [15:0]   RAM_RD_BSEL,
    input  logic          RAM_RD_RDY,
    output logic          RAM_RD_DVLD,
    output logic          RAM_RD_SOP,
    output logic          RAM_RD_EOP,
    output logic [DW-1:0] RAM_RD_DATA,
    output logic          RAM_RD_BUSY,
    output logic          RAM_RD_ERR
);

    localparam int BSH   = $clog2(DW / 8);
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } rd_state_t;

    // Address high bits, foreign select bits, sub-word size bits and the write
    // SOP marker carry no information for this block.
    logic unused_bits;
    assign unused_bits = ^{RAM_WR_SOP, RAM_WR_ADDR, RAM_RD_ADDR, RAM_WR_BSEL,
                           RAM_RD_BSEL, RAM_WR_SIZE, RAM_RD_SIZE};

    // ------------------------------------------------------------------
    // Reset: asserts asynchronously, releases two clock edges later.
    // ------------------------------------------------------------------
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge USER_CLK or negedge USER_RST_N) begin
        if (!USER_RST_N) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [DW-1:0] mem [DEPTH];
    logic          wr_en_q;
    logic [AW-1:0] wr_addr_q;
    logic [DW-1:0] wr_data_q;
    logic          rd_issue;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data_q;

    // NOTE: the array has no reset so it maps onto RAM macros and keeps its
    // contents across a reset; the non-blocking update is also what makes a
    // same-address read in the same cycle return the old word.
    always_ff @(posedge USER_CLK) begin
        if (wr_en_q) begin
            mem[wr_addr_q] <= wr_data_q;
        end
        if (rd_issue) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    // ------------------------------------------------------------------
    // Write port
    // ------------------------------------------------------------------
    logic [15:0]   wr_beats;
    logic          wr_take;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_left;
    logic [AW-1:0] wr_cur_addr;
    logic [15:0]   wr_cur_left;
    logic          wr_beat_ok;
    logic          wr_err_next;

    assign wr_beats = RAM_WR_SIZE >> BSH;
    assign wr_take  = RAM_WR_REQ && RAM_WR_BSEL[BSEL_ID] && (wr_beats != 16'd0);

    // A request landing with a beat redirects that beat to the new address.
    always_comb begin
        wr_cur_addr = wr_addr;
        wr_cur_left = wr_left;
        if (wr_take) begin
            wr_cur_addr = RAM_WR_ADDR[AW-1:0];
            wr_cur_left = wr_beats;
        end
    end

    assign wr_beat_ok  = RAM_WR_DVLD && (wr_cur_left != 16'd0);
    assign wr_err_next = RAM_WR_DVLD &&
                         ((wr_cur_left == 16'd0) || (RAM_WR_EOP && (wr_cur_left != 16'd1)));

    always_ff @(posedge USER_CLK or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr    <= '0;
            wr_left    <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            RAM_WR_ERR <= 1'b0;
        end else begin
            wr_addr    <= wr_cur_addr + AW'(wr_beat_ok);
            wr_left    <= wr_cur_left - 16'(wr_beat_ok);
            wr_en_q    <= wr_beat_ok;
            wr_addr_q  <= wr_cur_addr;
            wr_data_q  <= RAM_WR_DATA;
            RAM_WR_ERR <= wr_err_next;
        end
    end

    // ------------------------------------------------------------------
    // Read control
    // ------------------------------------------------------------------
    rd_state_t     rd_state;
    logic [15:0]   rd_beats;
    logic          rd_hit;
    logic [15:0]   rd_issue_left;
    logic          rd_first;
    logic          rd_vld_q;
    logic          rd_sop_q;
    logic          rd_eop_q;
    logic          rd_pop;
    logic [2:0]    rd_occ;

    logic [DW-1:0] buf_data [2];
    logic [1:0]    buf_sop;
    logic [1:0]    buf_eop;
    logic          buf_rptr;
    logic          buf_wptr;
    logic [1:0]    buf_cnt;

    assign rd_beats = RAM_RD_SIZE >> BSH;
    assign rd_hit   = RAM_RD_REQ && RAM_RD_BSEL[BSEL_ID] && (rd_beats != 16'd0);
    assign rd_pop   = RAM_RD_DVLD && RAM_RD_RDY;

    // Words held after this cycle's pop plus the one in flight from the RAM;
    // a new read issues only if it is guaranteed a buffer slot.
    assign rd_occ   = {1'b0, buf_cnt} + {2'b00, rd_vld_q} - {2'b00, rd_pop};
    assign rd_issue = (rd_state == FETCH) && (rd_issue_left != 16'd0) && (rd_occ < 3'd2);

    always_ff @(posedge USER_CLK or negedge rst_n) begin
        if (!rst_n) begin
            rd_state      <= IDLE;
            rd_addr       <= '0;
            rd_issue_left <= '0;
            rd_first      <= 1'b0;
            rd_vld_q      <= 1'b0;
            rd_sop_q      <= 1'b0;
            rd_eop_q      <= 1'b0;
            RAM_RD_BUSY   <= 1'b0;
            RAM_RD_ERR    <= 1'b0;
        end else begin
            RAM_RD_ERR <= rd_hit && (rd_state != IDLE);
            rd_vld_q   <= rd_issue;
            rd_sop_q   <= rd_issue && rd_first;
            rd_eop_q   <= rd_issue && (rd_issue_left == 16'd1);

            case (rd_state)
                IDLE: begin
                    if (rd_hit) begin
                        rd_state      <= FETCH;
                        rd_addr       <= RAM_RD_ADDR[AW-1:0];
                        rd_issue_left <= rd_beats;
                        rd_first      <= 1'b1;
                        RAM_RD_BUSY   <= 1'b1;
                    end
                end
                FETCH: begin
                    if (rd_issue) begin
                        rd_addr       <= rd_addr + AW'(1);
                        rd_issue_left <= rd_issue_left - 16'd1;
                        rd_first      <= 1'b0;
                        if (rd_issue_left == 16'd1) begin
                            rd_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (rd_pop && RAM_RD_EOP) begin
                        rd_state    <= IDLE;
                        RAM_RD_BUSY <= 1'b0;
                    end
                end
                default: begin
                    rd_state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Two-entry output skid buffer
    // ------------------------------------------------------------------
    always_ff @(posedge USER_CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                buf_data[i] <= '0;
            end
            buf_sop  <= '0;
            buf_eop  <= '0;
            buf_rptr <= 1'b0;
            buf_wptr <= 1'b0;
            buf_cnt  <= '0;
        end else begin
            if (rd_vld_q) begin
                buf_data[buf_wptr] <= rd_data_q;
                buf_sop[buf_wptr]  <= rd_sop_q;
                buf_eop[buf_wptr]  <= rd_eop_q;
                buf_wptr           <= ~buf_wptr;
            end
            if (rd_pop) begin
                buf_rptr <= ~buf_rptr;
            end
            buf_cnt <= buf_cnt + {1'b0, rd_vld_q} - {1'b0, rd_pop};
        end
    end

    assign RAM_RD_DVLD = (buf_cnt != 2'd0);
    assign RAM_RD_DATA = buf_data[buf_rptr];
    assign RAM_RD_SOP  = RAM_RD_DVLD && buf_sop[buf_rptr];
    assign RAM_RD_EOP  = RAM_RD_DVLD && buf_eop[buf_rptr];

endmodule
